// File: rtl/block_scheduler.sv
// Falling-block slot pool: spawn allocation, per-frame fall, lane hit matching,
// off-screen retirement and saturating hit/miss counters.
`timescale 1ns/1ps
module block_scheduler #(
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned LANE_X0    = 160,
    parameter int unsigned LANE_X1    = 260,
    parameter int unsigned LANE_X2    = 380,
    parameter int unsigned LANE_X3    = 480,
    parameter int unsigned Y_MAX      = 479,
    parameter int unsigned Y_STEP     = 1,
    parameter int unsigned HIT_Y_MIN  = 420,
    parameter int unsigned HIT_Y_MAX  = 460,
    parameter int unsigned BLOCK_SIZE = 12
) (
    input  logic                      frame_clk,
    input  logic                      Reset,
    input  logic                      Run,
    input  logic                      Spawn_Req,
    input  logic [1:0]                Spawn_Lane,
    input  logic [3:0]                Lane_Key,
    output logic [NUM_SLOTS-1:0]      Slot_Active,
    output logic [10*NUM_SLOTS-1:0]   Slot_X,
    output logic [10*NUM_SLOTS-1:0]   Slot_Y,
    output logic [9:0]                BlockS,
    output logic [3:0]                Hit_Pulse,
    output logic [3:0]                Miss_Pulse,
    output logic                      Spawn_Drop,
    output logic [15:0]               Hit_Count,
    output logic [15:0]               Miss_Count
);

    localparam int unsigned CW   = 10;
    localparam int unsigned NL   = 4;
    localparam int unsigned CNTW = 16;
    localparam int unsigned NW   = 4;

    // slot state
    logic [NUM_SLOTS-1:0] active_q;
    logic [CW-1:0]        x_q    [NUM_SLOTS];
    logic [CW-1:0]        y_q    [NUM_SLOTS];
    logic [1:0]           lane_q [NUM_SLOTS];
    logic [NL-1:0]        key_q;

    // next-state values
    logic [NUM_SLOTS-1:0] nxt_active;
    logic [CW-1:0]        nxt_x    [NUM_SLOTS];
    logic [CW-1:0]        nxt_y    [NUM_SLOTS];
    logic [1:0]           nxt_lane [NUM_SLOTS];
    logic [NL-1:0]        nxt_hit_pulse;
    logic [NL-1:0]        nxt_miss_pulse;
    logic                 nxt_drop;
    logic [CNTW-1:0]      nxt_hit_count;
    logic [CNTW-1:0]      nxt_miss_count;

    // decode
    logic [NL-1:0]        press;
    logic [NUM_SLOTS-1:0] sel [NL];
    logic [NUM_SLOTS-1:0] hit_c;
    logic [NUM_SLOTS-1:0] miss_c;
    logic [NUM_SLOTS-1:0] spawn_sel;
    logic                 any_free;
    logic [NW-1:0]        n_hit;
    logic [NW-1:0]        n_miss;

    function automatic logic [CW-1:0] lane_x(input logic [1:0] l);
        case (l)
            2'd0:    lane_x = CW'(LANE_X0);
            2'd1:    lane_x = CW'(LANE_X1);
            2'd2:    lane_x = CW'(LANE_X2);
            default: lane_x = CW'(LANE_X3);
        endcase
    endfunction

    function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] c, input logic [NW-1:0] n);
        logic [CNTW:0] s;
        s = {1'b0, c} + (CNTW+1)'(n);
        sat_add = s[CNTW] ? {CNTW{1'b1}} : s[CNTW-1:0];
    endfunction

    assign press       = Lane_Key & ~key_q;
    assign Slot_Active = active_q;
    assign BlockS      = CW'(BLOCK_SIZE);

    // flatten slot coordinates for the renderer
    always_comb begin
        Slot_X = '0;
        Slot_Y = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            Slot_X[10*i +: 10] = x_q[i];
            Slot_Y[10*i +: 10] = y_q[i];
        end
    end

    // per-lane hit candidate: deepest in-window block, lowest index on ties
    always_comb begin
        logic          found;
        logic [CW-1:0] best_y;
        for (int l = 0; l < NL; l++) begin
            sel[l] = '0;
            found  = 1'b0;
            best_y = '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (active_q[i] && (lane_q[i] == 2'(l)) &&
                    (y_q[i] >= CW'(HIT_Y_MIN)) && (y_q[i] <= CW'(HIT_Y_MAX)) &&
                    (!found || (y_q[i] > best_y))) begin
                    sel[l]    = '0;
                    sel[l][i] = 1'b1;
                    best_y    = y_q[i];
                    found     = 1'b1;
                end
            end
        end
    end

    // hit/miss classification, spawn slot choice and event counts
    always_comb begin
        hit_c     = '0;
        miss_c    = '0;
        spawn_sel = '0;
        any_free  = 1'b0;
        n_hit     = '0;
        n_miss    = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            hit_c[i]  = active_q[i] && press[lane_q[i]] && sel[lane_q[i]][i];
            miss_c[i] = active_q[i] && !hit_c[i] &&
                        (({1'b0, y_q[i]} + (CW+1)'(Y_STEP)) > (CW+1)'(Y_MAX));
            if (!active_q[i] && !any_free) begin
                spawn_sel[i] = 1'b1;
                any_free     = 1'b1;
            end
            n_hit  = n_hit  + NW'(hit_c[i]);
            n_miss = n_miss + NW'(miss_c[i]);
        end
    end

    // next-state for slots, pulses and counters; everything holds when not running
    always_comb begin
        nxt_active     = active_q;
        nxt_x          = x_q;
        nxt_y          = y_q;
        nxt_lane       = lane_q;
        nxt_hit_pulse  = '0;
        nxt_miss_pulse = '0;
        nxt_drop       = 1'b0;
        nxt_hit_count  = Hit_Count;
        nxt_miss_count = Miss_Count;
        if (Run) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (active_q[i]) begin
                    if (hit_c[i]) begin
                        nxt_active[i]             = 1'b0;
                        nxt_x[i]                  = '0;
                        nxt_y[i]                  = '0;
                        nxt_hit_pulse[lane_q[i]]  = 1'b1;
                    end else if (miss_c[i]) begin
                        nxt_active[i]             = 1'b0;
                        nxt_x[i]                  = '0;
                        nxt_y[i]                  = '0;
                        nxt_miss_pulse[lane_q[i]] = 1'b1;
                    end else begin
                        nxt_y[i] = y_q[i] + CW'(Y_STEP);
                    end
                end
            end
            if (Spawn_Req) begin
                if (any_free) begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (spawn_sel[i]) begin
                            nxt_active[i] = 1'b1;
                            nxt_x[i]      = lane_x(Spawn_Lane);
                            nxt_y[i]      = '0;
                            nxt_lane[i]   = Spawn_Lane;
                        end
                    end
                end else begin
                    nxt_drop = 1'b1;
                end
            end
            nxt_hit_count  = sat_add(Hit_Count, n_hit);
            nxt_miss_count = sat_add(Miss_Count, n_miss);
        end
    end

    // state and output registers; key edge register tracks keys even when frozen
    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            active_q   <= '0;
            key_q      <= '0;
            Hit_Pulse  <= '0;
            Miss_Pulse <= '0;
            Spawn_Drop <= 1'b0;
            Hit_Count  <= '0;
            Miss_Count <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i]    <= '0;
                y_q[i]    <= '0;
                lane_q[i] <= '0;
            end
        end else begin
            active_q   <= nxt_active;
            key_q      <= Lane_Key;
            Hit_Pulse  <= nxt_hit_pulse;
            Miss_Pulse <= nxt_miss_pulse;
            Spawn_Drop <= nxt_drop;
            Hit_Count  <= nxt_hit_count;
            Miss_Count <= nxt_miss_count;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i]    <= nxt_x[i];
                y_q[i]    <= nxt_y[i];
                lane_q[i] <= nxt_lane[i];
            end
        end
    end

endmodule

// File: tb/tb_block_scheduler.sv
// Scoreboard bench for block_scheduler: directed play sequences plus a short-screen
// instance that drives the miss counter into saturation.
`timescale 1ns/1ps
module tb_block_scheduler;

    typedef struct {
        logic [3:0]  hit;
        logic [3:0]  miss;
        logic        drop;
        logic [15:0] hc;
        logic [15:0] mc;
    } evt_t;

    logic        clk;
    logic        rst, run, spawn_req;
    logic [1:0]  spawn_lane;
    logic [3:0]  lane_key;
    logic [3:0]  slot_active;
    logic [39:0] slot_x, slot_y;
    logic [9:0]  block_s;
    logic [3:0]  hit_pulse, miss_pulse;
    logic        spawn_drop;
    logic [15:0] hit_count, miss_count;

    logic        s_rst, s_run, s_spawn;
    logic [1:0]  s_lane;
    logic [3:0]  s_key;
    logic [3:0]  s_active;
    logic [39:0] s_x, s_y;
    logic [9:0]  s_bs;
    logic [3:0]  s_hp, s_mp;
    logic        s_drop;
    logic [15:0] s_hc, s_mc;
    logic        sat_done;

    int   total = 0;
    int   bad   = 0;
    evt_t exp_q[$];
    logic [15:0] exp_hc = 0;
    logic [15:0] exp_mc = 0;

    block_scheduler dut (
        .frame_clk(clk), .Reset(rst), .Run(run), .Spawn_Req(spawn_req),
        .Spawn_Lane(spawn_lane), .Lane_Key(lane_key), .Slot_Active(slot_active),
        .Slot_X(slot_x), .Slot_Y(slot_y), .BlockS(block_s), .Hit_Pulse(hit_pulse),
        .Miss_Pulse(miss_pulse), .Spawn_Drop(spawn_drop), .Hit_Count(hit_count),
        .Miss_Count(miss_count)
    );

    block_scheduler #(.Y_MAX(0)) dut_sat (
        .frame_clk(clk), .Reset(s_rst), .Run(s_run), .Spawn_Req(s_spawn),
        .Spawn_Lane(s_lane), .Lane_Key(s_key), .Slot_Active(s_active),
        .Slot_X(s_x), .Slot_Y(s_y), .BlockS(s_bs), .Hit_Pulse(s_hp),
        .Miss_Pulse(s_mp), .Spawn_Drop(s_drop), .Hit_Count(s_hc),
        .Miss_Count(s_mc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] sy(input int s);
        return slot_y[10*s +: 10];
    endfunction

    function automatic logic [9:0] sx(input int s);
        return slot_x[10*s +: 10];
    endfunction

    task automatic expect_evt(input logic [3:0] h, input logic [3:0] m, input logic d,
                              input int nh, input int nm);
        evt_t e;
        exp_hc = exp_hc + 16'(nh);
        exp_mc = exp_mc + 16'(nm);
        e.hit = h; e.miss = m; e.drop = d; e.hc = exp_hc; e.mc = exp_mc;
        exp_q.push_back(e);
    endtask

    task automatic run_to_y(input int s, input logic [9:0] target);
        for (int n = 0; n < 1000 && sy(s) != target; n++) tick();
        chk("run_to_y", 64'(sy(s)), 64'(target));
    endtask

    // monitor: every pulse on the main instance must match the next queued event
    always @(negedge clk) begin
        evt_t e;
        if (hit_pulse != 4'd0 || miss_pulse != 4'd0 || spawn_drop) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse hit=%b miss=%b drop=%b", hit_pulse, miss_pulse, spawn_drop);
            end else begin
                e = exp_q.pop_front();
                chk("evt_hit_pulse",  64'(hit_pulse),  64'(e.hit));
                chk("evt_miss_pulse", 64'(miss_pulse), 64'(e.miss));
                chk("evt_drop",       64'(spawn_drop), 64'(e.drop));
                chk("evt_hit_count",  64'(hit_count),  64'(e.hc));
                chk("evt_miss_count", 64'(miss_count), 64'(e.mc));
            end
        end
    end

    // saturation: one miss per frame on a zero-height screen
    initial begin
        sat_done = 1'b0;
        s_rst = 1'b0; s_run = 1'b1; s_spawn = 1'b1; s_lane = 2'd3; s_key = 4'd0;
        tick(); tick();
        s_rst = 1'b1;
        repeat (100) tick();
        chk("sat_count_100", 64'(s_mc), 64'd99);
        repeat (65440) tick();
        chk("sat_reached", 64'(s_mc), 64'hFFFF);
        repeat (10) tick();
        chk("sat_hold", 64'(s_mc), 64'hFFFF);
        sat_done = 1'b1;
    end

    initial begin
        rst = 1'b0; run = 1'b0; spawn_req = 1'b0; spawn_lane = 2'd0; lane_key = 4'd0;
        tick(); tick();
        chk("rst_active", 64'(slot_active), 64'd0);
        chk("rst_x", 64'(slot_x), 64'd0);
        chk("rst_y", 64'(slot_y), 64'd0);
        chk("rst_counts", 64'({hit_count, miss_count}), 64'd0);
        chk("rst_pulses", 64'({hit_pulse, miss_pulse, spawn_drop}), 64'd0);
        chk("block_size", 64'(block_s), 64'd12);
        rst = 1'b1; run = 1'b1;
        repeat (10) tick();
        chk("idle_active", 64'(slot_active), 64'd0);
        chk("idle_counts", 64'({hit_count, miss_count}), 64'd0);

        // single block falls off the screen
        spawn_req = 1'b1; spawn_lane = 2'd2;
        tick();
        spawn_req = 1'b0;
        chk("spawn_active", 64'(slot_active), 64'b0001);
        chk("spawn_x", 64'(sx(0)), 64'd380);
        chk("spawn_y", 64'(sy(0)), 64'd0);
        tick();
        chk("fall_y1", 64'(sy(0)), 64'd1);
        run_to_y(0, 10'd479);
        chk("bottom_active", 64'(slot_active), 64'b0001);
        expect_evt(4'b0000, 4'b0100, 1'b0, 0, 1);
        tick();
        chk("miss_retired", 64'(slot_active), 64'd0);
        chk("miss_y0", 64'(sy(0)), 64'd0);
        chk("miss_x0", 64'(sx(0)), 64'd0);
        tick();
        chk("miss_pulse_once", 64'(miss_pulse), 64'd0);

        // held key does not hit; fresh edge inside the window does
        spawn_req = 1'b1; spawn_lane = 2'd0;
        tick();
        spawn_req = 1'b0;
        run_to_y(0, 10'd100);
        lane_key = 4'b0001;
        run_to_y(0, 10'd425);
        chk("held_no_hit", 64'(slot_active), 64'b0001);
        lane_key = 4'b0000;
        run_to_y(0, 10'd430);
        lane_key = 4'b0001;
        expect_evt(4'b0001, 4'b0000, 1'b0, 1, 0);
        tick();
        lane_key = 4'b0000;
        chk("hit_retired", 64'(slot_active), 64'd0);

        // presses just outside the window
        spawn_req = 1'b1;
        tick();
        spawn_req = 1'b0;
        run_to_y(0, 10'd419);
        lane_key = 4'b0001;
        tick();
        lane_key = 4'b0000;
        chk("edge419_active", 64'(slot_active), 64'b0001);
        chk("edge419_y", 64'(sy(0)), 64'd420);
        run_to_y(0, 10'd461);
        lane_key = 4'b0001;
        tick();
        lane_key = 4'b0000;
        chk("edge461_active", 64'(slot_active), 64'b0001);
        chk("edge461_y", 64'(sy(0)), 64'd462);
        run_to_y(0, 10'd479);
        expect_evt(4'b0000, 4'b0001, 1'b0, 0, 1);
        tick();

        // fill all slots, fifth spawn dropped
        spawn_req = 1'b1; spawn_lane = 2'd1;
        repeat (4) tick();
        expect_evt(4'b0000, 4'b0000, 1'b1, 0, 0);
        tick();
        spawn_req = 1'b0;
        chk("full_active", 64'(slot_active), 64'b1111);
        for (int i = 0; i < 4; i++) begin
            chk("fill_y", 64'(sy(i)), 64'(4 - i));
            chk("fill_x", 64'(sx(i)), 64'd260);
        end

        // hit plus spawn on the same edge: freed slot not yet reusable
        run_to_y(0, 10'd450);
        chk("stagger_y3", 64'(sy(3)), 64'd447);
        lane_key = 4'b0010; spawn_req = 1'b1; spawn_lane = 2'd3;
        expect_evt(4'b0010, 4'b0000, 1'b1, 1, 0);
        tick();
        lane_key = 4'b0000;
        chk("deepest_hit", 64'(slot_active), 64'b1110);
        chk("survivor_y", 64'(sy(1)), 64'd450);
        tick();
        spawn_req = 1'b0;
        chk("reuse_active", 64'(slot_active), 64'b1111);
        chk("reuse_x", 64'(sx(0)), 64'd480);
        chk("reuse_y", 64'(sy(0)), 64'd0);
        chk("reuse_y1", 64'(sy(1)), 64'd451);

        // frozen: no motion, presses and spawns ignored
        run = 1'b0;
        for (int f = 0; f < 20; f++) begin
            lane_key = (f % 2 == 0) ? 4'hF : 4'h0;
            spawn_req = 1'b1;
            tick();
        end
        spawn_req = 1'b0; lane_key = 4'd0;
        chk("frz_active", 64'(slot_active), 64'b1111);
        chk("frz_y0", 64'(sy(0)), 64'd0);
        chk("frz_y1", 64'(sy(1)), 64'd451);
        chk("frz_y3", 64'(sy(3)), 64'd449);
        chk("frz_counts", 64'({hit_count, miss_count}), 64'({16'd2, 16'd2}));
        run = 1'b1;
        tick();
        chk("thaw_y0", 64'(sy(0)), 64'd1);
        chk("thaw_y1", 64'(sy(1)), 64'd452);

        // drain the lane-1 blocks, then the lane-3 block
        run_to_y(1, 10'd479);
        for (int k = 0; k < 3; k++) begin
            expect_evt(4'b0000, 4'b0010, 1'b0, 0, 1);
            tick();
        end
        chk("drain_active", 64'(slot_active), 64'b0001);
        chk("drain_y0", 64'(sy(0)), 64'd31);
        run_to_y(0, 10'd479);
        expect_evt(4'b0000, 4'b1000, 1'b0, 0, 1);
        tick();
        chk("empty_active", 64'(slot_active), 64'd0);

        // two lane-1 blocks four rows apart: one press takes the lower one
        spawn_req = 1'b1; spawn_lane = 2'd1;
        tick();
        spawn_req = 1'b0;
        repeat (3) tick();
        spawn_req = 1'b1;
        tick();
        spawn_req = 1'b0;
        chk("pair_y0", 64'(sy(0)), 64'd4);
        chk("pair_y1", 64'(sy(1)), 64'd0);
        run_to_y(0, 10'd440);
        chk("pair_y1_436", 64'(sy(1)), 64'd436);
        lane_key = 4'b0010;
        expect_evt(4'b0010, 4'b0000, 1'b0, 1, 0);
        tick();
        lane_key = 4'b0000;
        chk("pair_active", 64'(slot_active), 64'b0010);
        chk("pair_left_y", 64'(sy(1)), 64'd437);
        run_to_y(1, 10'd479);
        expect_evt(4'b0000, 4'b0010, 1'b0, 0, 1);
        tick();
        tick(); tick();
        chk("final_hits", 64'(hit_count), 64'd3);
        chk("final_misses", 64'(miss_count), 64'd7);
        chk("final_active", 64'(slot_active), 64'd0);
        chk("pending_events", 64'(exp_q.size()), 64'd0);

        wait (sat_done);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
